ray_dispatch: RTL and testbench

- Frame-level ray initiator for the box intersector: scans an H_RES x V_RES pixel grid in raster order and builds the 31-bit ray direction for each pixel.
- Per pixel, it restarts the tracer, waits the tracer's fixed latency, then captures its 10-bit t result.
- Each result goes out on a valid/ready pixel-write port toward the frame store / shading stage.

---
 rtl/ray_pkg.sv | 25 ++
 rtl/ray_dispatch_if.sv | 26 ++
 rtl/ray_dir_gen.sv | 21 ++
 rtl/ray_dispatch.sv | 166 ++++++++++++++++
 tb/tb_ray_dispatch.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared widths, constants, state enum and direction packing for ray_dispatch
// Field layout of the 31-bit tracer direction word: {dx signed, dy signed, dz unsigned}.
package ray_pkg;
  localparam int DIR_DX_W = 11;
  localparam int DIR_DY_W = 11;
  localparam int DIR_DZ_W = 9;
  localparam int DIR_W    = DIR_DX_W + DIR_DY_W + DIR_DZ_W;
  localparam int ORIGIN_W = 28;
  localparam int T_W      = 10;

  localparam logic [T_W-1:0] T_MISS = 10'h3FF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_EMIT
  } dispatch_state_e;

  function automatic logic [DIR_W-1:0] pack_dir(input logic [DIR_DX_W-1:0] dx,
                                                input logic [DIR_DY_W-1:0] dy,
                                                input logic [DIR_DZ_W-1:0] dz);
    return {dx, dy, dz};
  endfunction
endpackage

// File: rtl/ray_dispatch_if.sv
// rtl/ray_dispatch_if.sv - tracer control and pixel-write bus between dispatcher and its neighbours
// master = dispatcher side; slave = tracer/frame-store side.
interface ray_dispatch_if #(
  parameter int ADDR_W = 12
);
  import ray_pkg::*;

  logic                trace_rst;
  logic [ORIGIN_W-1:0] trace_init;
  logic [DIR_W-1:0]    trace_dir;
  logic [T_W-1:0]      trace_t;
  logic                pix_valid;
  logic                pix_ready;
  logic [ADDR_W-1:0]   pix_addr;
  logic [T_W-1:0]      pix_t;

  modport master (
    output trace_rst, trace_init, trace_dir, pix_valid, pix_addr, pix_t,
    input  trace_t, pix_ready
  );

  modport slave (
    input  trace_rst, trace_init, trace_dir, pix_valid, pix_addr, pix_t,
    output trace_t, pix_ready
  );
endinterface

// File: rtl/ray_dir_gen.sv
// rtl/ray_dir_gen.sv - combinational pixel coordinate to packed ray direction
// Image centre maps to dx=dy=0; dy grows upward so row 0 is the top of the frame.
module ray_dir_gen import ray_pkg::*; #(
  parameter int H_RES  = 64,
  parameter int V_RES  = 48,
  parameter int FOCAL  = 64,
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] px,
  input  logic [ADDR_W-1:0] py,
  output logic [DIR_W-1:0]  dir
);
  logic [DIR_DX_W-1:0] dx;
  logic [DIR_DY_W-1:0] dy;

  always_comb begin
    dx  = DIR_DX_W'(px) - DIR_DX_W'(H_RES / 2);
    dy  = DIR_DY_W'(V_RES / 2) - DIR_DY_W'(py);
    dir = pack_dir(dx, dy, DIR_DZ_W'(FOCAL));
  end
endmodule

// File: rtl/ray_dispatch.sv
// rtl/ray_dispatch.sv - raster-order ray initiator: restarts the tracer per pixel and emits its t result
// All outputs are registered; the next-state logic decides every output for the following cycle.
module ray_dispatch import ray_pkg::*; #(
  parameter int H_RES     = 64,
  parameter int V_RES     = 48,
  parameter int FOCAL     = 64,
  parameter int TRACE_LAT = 16,
  parameter int ADDR_W    = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [ORIGIN_W-1:0] cam_origin,
  ray_dispatch_if.master      bus,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     hit_count
);
  localparam int CNT_W = $clog2(TRACE_LAT + 1);
  localparam logic [ADDR_W-1:0] PX_LAST = ADDR_W'(H_RES - 1);
  localparam logic [ADDR_W-1:0] PY_LAST = ADDR_W'(V_RES - 1);

  dispatch_state_e     state_q, state_d;
  logic [ADDR_W-1:0]   px_q, px_d, py_q, py_d;
  logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                trace_rst_q, trace_rst_d;
  logic                pix_valid_q, pix_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ORIGIN_W-1:0] trace_init_q, trace_init_d;
  logic [DIR_W-1:0]    trace_dir_q, trace_dir_d, dir_next;
  logic [T_W-1:0]      pix_t_q, pix_t_d;
  logic [ADDR_W:0]     hit_q, hit_d;

  // Fed with the next coordinate so the direction is ready on the LOAD edge.
  ray_dir_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .FOCAL (FOCAL),
    .ADDR_W(ADDR_W)
  ) u_dir_gen (
    .px (px_d),
    .py (py_d),
    .dir(dir_next)
  );

  always_comb begin
    state_d      = state_q;
    px_d         = px_q;
    py_d         = py_q;
    pix_addr_d   = pix_addr_q;
    cnt_d        = cnt_q;
    trace_init_d = trace_init_q;
    trace_dir_d  = trace_dir_q;
    pix_t_d      = pix_t_q;
    hit_d        = hit_q;
    done_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_LOAD;
          px_d         = '0;
          py_d         = '0;
          hit_d        = '0;
          trace_init_d = cam_origin;
        end
      end
      ST_LOAD: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(TRACE_LAT);
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = ST_EMIT;
          pix_t_d    = bus.trace_t;
          pix_addr_d = ADDR_W'(py_q * H_RES + px_q);
          if (bus.trace_t != T_MISS) begin
            hit_d = hit_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (bus.pix_ready) begin
          if (px_q == PX_LAST && py_q == PY_LAST) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
            if (px_q == PX_LAST) begin
              px_d = '0;
              py_d = py_q + 1'b1;
            end else begin
              px_d = px_q + 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort discards whatever this cycle would have committed, including an acceptance.
    if (abort && state_q != ST_IDLE) begin
      state_d    = ST_IDLE;
      px_d       = px_q;
      py_d       = py_q;
      pix_addr_d = pix_addr_q;
      pix_t_d    = pix_t_q;
      hit_d      = hit_q;
      done_d     = 1'b0;
    end

    if (state_d == ST_LOAD) begin
      trace_dir_d = dir_next;
    end

    trace_rst_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    pix_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      px_q         <= '0;
      py_q         <= '0;
      pix_addr_q   <= '0;
      cnt_q        <= '0;
      trace_rst_q  <= 1'b1;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      trace_init_q <= '0;
      trace_dir_q  <= '0;
      pix_t_q      <= '0;
      hit_q        <= '0;
    end else begin
      state_q      <= state_d;
      px_q         <= px_d;
      py_q         <= py_d;
      pix_addr_q   <= pix_addr_d;
      cnt_q        <= cnt_d;
      trace_rst_q  <= trace_rst_d;
      pix_valid_q  <= pix_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      trace_init_q <= trace_init_d;
      trace_dir_q  <= trace_dir_d;
      pix_t_q      <= pix_t_d;
      hit_q        <= hit_d;
    end
  end

  assign bus.trace_rst  = trace_rst_q;
  assign bus.trace_init = trace_init_q;
  assign bus.trace_dir  = trace_dir_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_addr   = pix_addr_q;
  assign bus.pix_t      = pix_t_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign hit_count      = hit_q;
endmodule

// File: tb/tb_ray_dispatch.sv
// tb/tb_ray_dispatch.sv - directed self-checking bench for ray_dispatch on a 4x2 frame
// Cycle k below means the interval after the (k-1)th edge following the start-sampling edge.
module tb_ray_dispatch;
  import ray_pkg::*;

  localparam int H_RES     = 4;
  localparam int V_RES     = 2;
  localparam int FOCAL     = 8;
  localparam int TRACE_LAT = 4;
  localparam int ADDR_W    = 3;

  localparam logic [DIR_W-1:0]    DIR_FIRST = {11'h7FE, 11'h001, 9'h008};
  localparam logic [DIR_W-1:0]    DIR_LAST  = {11'h001, 11'h000, 9'h008};
  localparam logic [ORIGIN_W-1:0] ORIGIN    = 28'hA5C371E;
  localparam logic [T_W-1:0]      T_EARLY   = 10'h155;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [ORIGIN_W-1:0] cam_origin = '0;
  logic                busy, done;
  logic [ADDR_W:0]     hit_count;

  int checks = 0;
  int errors = 0;

  ray_dispatch_if #(.ADDR_W(ADDR_W)) bus_if ();

  ray_dispatch #(
    .H_RES    (H_RES),
    .V_RES    (V_RES),
    .FOCAL    (FOCAL),
    .TRACE_LAT(TRACE_LAT),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cam_origin(cam_origin),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [T_W-1:0] exp_t(input int a);
    return (a % 2 == 1) ? 10'd37 : T_MISS;
  endfunction

  // Tracer model: result depends on the pixel encoded in trace_dir, valid only after TRACE_LAT.
  int trc_cnt = 0;
  int m_px, m_py;
  always @(posedge clk) begin
    if (bus_if.trace_rst) trc_cnt <= 0;
    else trc_cnt <= trc_cnt + 1;
  end
  always_comb begin
    m_px = int'($signed(bus_if.trace_dir[30:20])) + H_RES / 2;
    m_py = V_RES / 2 - int'($signed(bus_if.trace_dir[19:9]));
    bus_if.trace_t = (trc_cnt >= TRACE_LAT - 1) ? exp_t(m_py * H_RES + m_px) : T_EARLY;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.pix_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus_if.trace_rst !== 1'b1) begin errors++; $display("FAIL reset_trace_rst got %0h want 1", bus_if.trace_rst); end
    checks++; if (bus_if.trace_dir !== '0) begin errors++; $display("FAIL reset_trace_dir got %0h want 0", bus_if.trace_dir); end
    checks++; if (bus_if.pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %0h want 0", bus_if.pix_valid); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %0h/%0h want 0/0", busy, done); end
    checks++; if (hit_count !== '0) begin errors++; $display("FAIL reset_hit_count got %0h want 0", hit_count); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_frame;
    int n = 0;
    int done_cyc = -1;
    cam_origin = ORIGIN;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (bus_if.trace_dir !== DIR_FIRST) begin errors++; $display("FAIL frame_first_dir got %0h want %0h", bus_if.trace_dir, DIR_FIRST); end
    checks++; if (bus_if.trace_rst !== 1'b1) begin errors++; $display("FAIL frame_load_trace_rst got %0h want 1", bus_if.trace_rst); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_load_busy got %0h want 1", busy); end
    checks++; if (bus_if.trace_init !== ORIGIN) begin errors++; $display("FAIL frame_trace_init got %0h want %0h", bus_if.trace_init, ORIGIN); end
    cam_origin = '0;
    for (int cyc = 2; cyc <= 55; cyc++) begin
      start = (cyc == 10);
      tick();
      if (cyc == 43) begin
        checks++; if (bus_if.trace_dir !== DIR_LAST) begin errors++; $display("FAIL frame_last_dir got %0h want %0h", bus_if.trace_dir, DIR_LAST); end
      end
      if (bus_if.pix_valid === 1'b1) begin
        checks++; if (cyc != 6 * (n + 1)) begin errors++; $display("FAIL frame_valid_cycle got %0d want %0d", cyc, 6 * (n + 1)); end
        checks++; if (bus_if.pix_addr !== ADDR_W'(n)) begin errors++; $display("FAIL frame_addr got %0d want %0d", bus_if.pix_addr, n); end
        checks++; if (bus_if.pix_t !== exp_t(n)) begin errors++; $display("FAIL frame_pix_t addr %0d got %0h want %0h", n, bus_if.pix_t, exp_t(n)); end
        n++;
      end
      if (done === 1'b1) begin
        done_cyc = (done_cyc == -1) ? cyc : -2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_at_done got %0h want 0", busy); end
        checks++; if (hit_count !== 4'd4) begin errors++; $display("FAIL frame_hit_count got %0d want 4", hit_count); end
      end
    end
    start = 1'b0;
    checks++; if (n != 8) begin errors++; $display("FAIL frame_pixel_count got %0d want 8", n); end
    checks++; if (done_cyc != 49) begin errors++; $display("FAIL frame_done_cycle got %0d want 49", done_cyc); end
    checks++; if (bus_if.trace_init !== ORIGIN) begin errors++; $display("FAIL frame_init_held got %0h want %0h", bus_if.trace_init, ORIGIN); end
  endtask

  task automatic test_backpressure;
    int n = 0;
    int done_cyc = -1;
    int stall_left = 0;
    bit stalled = 1'b0;
    bus_if.pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 2; cyc <= 65; cyc++) begin
      tick();
      if (bus_if.pix_valid === 1'b1 && bus_if.pix_addr === 3'd2 && !stalled) begin
        stalled = 1'b1;
        stall_left = 10;
      end
      if (stall_left > 0) begin
        bus_if.pix_ready = 1'b0;
        checks++; if (bus_if.pix_valid !== 1'b1 || bus_if.pix_addr !== 3'd2) begin errors++; $display("FAIL stall_hold valid/addr got %0h/%0d want 1/2", bus_if.pix_valid, bus_if.pix_addr); end
        checks++; if (bus_if.pix_t !== T_MISS) begin errors++; $display("FAIL stall_pix_t got %0h want %0h", bus_if.pix_t, T_MISS); end
        checks++; if (bus_if.trace_rst !== 1'b0) begin errors++; $display("FAIL stall_trace_rst got %0h want 0", bus_if.trace_rst); end
        stall_left--;
      end else begin
        bus_if.pix_ready = 1'b1;
        if (bus_if.pix_valid === 1'b1) begin
          checks++; if (cyc != 6 * (n + 1) + ((n >= 2) ? 10 : 0)) begin errors++; $display("FAIL stall_valid_cycle pixel %0d got %0d", n, cyc); end
          checks++; if (bus_if.pix_addr !== ADDR_W'(n)) begin errors++; $display("FAIL stall_addr got %0d want %0d", bus_if.pix_addr, n); end
          n++;
        end
      end
      if (done === 1'b1) begin
        done_cyc = (done_cyc == -1) ? cyc : -2;
        checks++; if (hit_count !== 4'd4) begin errors++; $display("FAIL stall_hit_count got %0d want 4", hit_count); end
      end
    end
    bus_if.pix_ready = 1'b1;
    checks++; if (done_cyc != 59) begin errors++; $display("FAIL stall_done_cycle got %0d want 59", done_cyc); end
    checks++; if (n != 8) begin errors++; $display("FAIL stall_pixel_count got %0d want 8", n); end
  endtask

  task automatic test_abort;
    int late_valid = 0;
    int late_done = 0;
    int done_seen = 0;
    bus_if.pix_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 2; cyc <= 21; cyc++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0h want 0", busy); end
    checks++; if (bus_if.trace_rst !== 1'b1) begin errors++; $display("FAIL abort_trace_rst got %0h want 1", bus_if.trace_rst); end
    checks++; if (hit_count !== 4'd1) begin errors++; $display("FAIL abort_hit_frozen got %0d want 1", hit_count); end
    for (int i = 0; i < 20; i++) begin
      if (bus_if.pix_valid === 1'b1) late_valid++;
      if (done === 1'b1) late_done++;
      tick();
    end
    checks++; if (late_valid != 0 || late_done != 0) begin errors++; $display("FAIL abort_quiet valid %0d done %0d want 0 0", late_valid, late_done); end
    checks++; if (hit_count !== 4'd1) begin errors++; $display("FAIL abort_hit_after got %0d want 1", hit_count); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (hit_count !== '0) begin errors++; $display("FAIL restart_hit_clear got %0d want 0", hit_count); end
    checks++; if (bus_if.trace_dir !== DIR_FIRST) begin errors++; $display("FAIL restart_dir got %0h want %0h", bus_if.trace_dir, DIR_FIRST); end
    for (int cyc = 2; cyc <= 6; cyc++) tick();
    checks++; if (bus_if.pix_valid !== 1'b1 || bus_if.pix_addr !== 3'd0) begin errors++; $display("FAIL restart_first_pixel valid/addr got %0h/%0d want 1/0", bus_if.pix_valid, bus_if.pix_addr); end
    for (int i = 0; i < 60 && done_seen == 0; i++) begin
      tick();
      if (done === 1'b1) done_seen = 1;
    end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL restart_done got %0d want 1", done_seen); end
  endtask

  task automatic test_rst_emit;
    bus_if.pix_ready = 1'b0;
    cam_origin = ORIGIN;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 2; cyc <= 6; cyc++) tick();
    checks++; if (bus_if.pix_valid !== 1'b1 || bus_if.pix_t !== T_MISS) begin errors++; $display("FAIL rst_pre_emit valid/t got %0h/%0h want 1/%0h", bus_if.pix_valid, bus_if.pix_t, T_MISS); end
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checks++; if (bus_if.trace_rst !== 1'b1 || bus_if.pix_valid !== 1'b0) begin errors++; $display("FAIL rst_emit trace_rst/valid got %0h/%0h want 1/0", bus_if.trace_rst, bus_if.pix_valid); end
    checks++; if (bus_if.pix_t !== '0 || bus_if.pix_addr !== '0) begin errors++; $display("FAIL rst_emit pix_t/addr got %0h/%0h want 0/0", bus_if.pix_t, bus_if.pix_addr); end
    checks++; if (bus_if.trace_init !== '0 || bus_if.trace_dir !== '0) begin errors++; $display("FAIL rst_emit init/dir got %0h/%0h want 0/0", bus_if.trace_init, bus_if.trace_dir); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || hit_count !== '0) begin errors++; $display("FAIL rst_emit busy/done/hits got %0h/%0h/%0h want 0/0/0", busy, done, hit_count); end
    tick();
    tick();
    checks++; if (busy !== 1'b0 || bus_if.trace_dir !== '0) begin errors++; $display("FAIL rst_start_ignored busy/dir got %0h/%0h want 0/0", busy, bus_if.trace_dir); end
    bus_if.pix_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    tick();
    test_backpressure();
    tick();
    test_abort();
    tick();
    test_rst_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
